// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if: asynchronous source pointers in, synchronized pointer views out.
interface gray_ptr_sync_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int CHANNELS = 1
);
    localparam int W = CHANNELS * (ADDR_WIDTH + 1);
    logic [W-1:0] wptr_gray;
    logic err_clr;
    logic [W-1:0] rq_gray;
    logic [W-1:0] rq_bin;
    logic [W-1:0] rq_delta;
    logic [CHANNELS-1:0] ptr_adv;
    logic [CHANNELS-1:0] gray_err;
    modport master (output wptr_gray, err_clr, input rq_gray, rq_bin, rq_delta, ptr_adv, gray_err);
    modport slave (input wptr_gray, err_clr, output rq_gray, rq_bin, rq_delta, ptr_adv, gray_err);
endinterface

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: per-channel Gray pointer synchronizer with binary conversion,
// advance tracking and a sticky flag for illegal (backward / corrupt) motion.
module gray_ptr_sync #(
    parameter int ADDR_WIDTH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CHANNELS = 1
) (
    input logic rclk,
    input logic rrst,
    gray_ptr_sync_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int W = CHANNELS * PW;
    localparam logic [PW-1:0] HALF = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] rq_gray, rq_bin, rq_delta, bin_next, delta_next;
    logic [CHANNELS-1:0] ptr_adv, gray_err, adv_next, err_set;

    assign rq_gray = sync_q[SYNC_STAGES-1];

    // A change is always a nonzero delta, so rq_delta==0 marks "no advance since
    // reset"; that first jump from the reset value is never flagged as an error.
    always_comb begin
        bin_next = '0;
        delta_next = '0;
        adv_next = '0;
        err_set = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < PW; i++) bin_next[c*PW+i] = ^(rq_gray[c*PW +: PW] >> i);
            adv_next[c] = bin_next[c*PW +: PW] != rq_bin[c*PW +: PW];
            delta_next[c*PW +: PW] = adv_next[c] ? bin_next[c*PW +: PW] - rq_bin[c*PW +: PW] : rq_delta[c*PW +: PW];
            err_set[c] = adv_next[c] && rq_delta[c*PW +: PW] != '0 && delta_next[c*PW +: PW] > HALF;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            sync_q <= '0;
            rq_bin <= '0;
            rq_delta <= '0;
            ptr_adv <= '0;
            gray_err <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.wptr_gray};
            rq_bin <= bin_next;
            rq_delta <= delta_next;
            ptr_adv <= adv_next;
            gray_err <= err_set | (gray_err & ~{CHANNELS{bus.err_clr}});
        end
    end

    assign bus.rq_gray = rq_gray;
    assign bus.rq_bin = rq_bin;
    assign bus.rq_delta = rq_delta;
    assign bus.ptr_adv = ptr_adv;
    assign bus.gray_err = gray_err;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: table-driven single-channel checks plus a hand-written
// three-stage, two-channel latency/independence sequence.
module tb_gray_ptr_sync;
    typedef struct packed {
        logic rst;
        logic [4:0] w;
        logic clr;
        logic [4:0] g;
        logic [4:0] b;
        logic [4:0] d;
        logic adv;
        logic err;
    } vec_t;

    typedef struct packed {
        logic [9:0] g;
        logic [9:0] b;
        logic [9:0] d;
        logic [1:0] adv;
        logic [1:0] err;
    } exp_b_t;

    logic rclk = 0;
    logic rrst = 1;
    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    exp_b_t exp_bq[$];

    always #5 rclk = ~rclk;

    gray_ptr_sync_if #(.ADDR_WIDTH(4), .CHANNELS(1)) a_if ();
    gray_ptr_sync_if #(.ADDR_WIDTH(4), .CHANNELS(2)) b_if ();

    gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .CHANNELS(1)) dut_a (
        .rclk(rclk), .rrst(rrst), .bus(a_if.slave));
    gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .CHANNELS(2)) dut_b (
        .rclk(rclk), .rrst(rrst), .bus(b_if.slave));

    task automatic add(input logic rst, input logic [4:0] w, input logic clr,
                       input logic [4:0] g, input logic [4:0] b, input logic [4:0] d,
                       input logic adv, input logic err);
        vecs.push_back('{rst, w, clr, g, b, d, adv, err});
    endtask

    task automatic step_a(input vec_t v, input int idx);
        vec_t e;
        @(negedge rclk);
        rrst = v.rst;
        a_if.wptr_gray = v.w;
        a_if.err_clr = v.clr;
        exp_q.push_back(v);
        @(posedge rclk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if ({a_if.rq_gray, a_if.rq_bin, a_if.rq_delta, a_if.ptr_adv, a_if.gray_err} !== {e.g, e.b, e.d, e.adv, e.err}) begin
            n_err++;
            $display("FAIL vec%0d: got gray=%b bin=%0d delta=%0d adv=%b err=%b, want gray=%b bin=%0d delta=%0d adv=%b err=%b",
                     idx, a_if.rq_gray, a_if.rq_bin, a_if.rq_delta, a_if.ptr_adv, a_if.gray_err,
                     e.g, e.b, e.d, e.adv, e.err);
        end
    endtask

    task automatic step_b(input string name, input logic rst, input logic [9:0] w, input exp_b_t x);
        exp_b_t e;
        @(negedge rclk);
        rrst = rst;
        b_if.wptr_gray = w;
        exp_bq.push_back(x);
        @(posedge rclk);
        #1;
        e = exp_bq.pop_front();
        n_vec++;
        if ({b_if.rq_gray, b_if.rq_bin, b_if.rq_delta, b_if.ptr_adv, b_if.gray_err} !== e) begin
            n_err++;
            $display("FAIL %s: got gray=%b bin=%b delta=%b adv=%b err=%b, want gray=%b bin=%b delta=%b adv=%b err=%b",
                     name, b_if.rq_gray, b_if.rq_bin, b_if.rq_delta, b_if.ptr_adv, b_if.gray_err,
                     e.g, e.b, e.d, e.adv, e.err);
        end
    endtask

    initial begin
        exp_b_t settled, c1_seen, c1_adv, c1_done;
        a_if.wptr_gray = '0;
        a_if.err_clr = 0;
        b_if.wptr_gray = '0;
        b_if.err_clr = 0;
        // reset held with a nonzero pointer, then release
        repeat (3) add(1, 5'b10000, 0, 5'b00000, 0, 0, 0, 0);
        add(0, 5'b10000, 0, 5'b00000, 0, 0, 0, 0);
        add(0, 5'b10000, 0, 5'b10000, 0, 0, 0, 0);
        add(0, 5'b10000, 0, 5'b10000, 31, 31, 1, 0);
        add(0, 5'b10000, 0, 5'b10000, 31, 31, 0, 0);
        // wrap 31 -> 0
        add(0, 5'b00000, 0, 5'b10000, 31, 31, 0, 0);
        add(0, 5'b00000, 0, 5'b00000, 31, 31, 0, 0);
        add(0, 5'b00000, 0, 5'b00000, 0, 1, 1, 0);
        add(0, 5'b00000, 0, 5'b00000, 0, 1, 0, 0);
        // latency 0 -> 1
        add(0, 5'b00001, 0, 5'b00000, 0, 1, 0, 0);
        add(0, 5'b00001, 0, 5'b00001, 0, 1, 0, 0);
        add(0, 5'b00001, 0, 5'b00001, 1, 1, 1, 0);
        add(0, 5'b00001, 0, 5'b00001, 1, 1, 0, 0);
        // 1 -> 3, then multi-step 3 -> 7
        add(0, 5'b00010, 0, 5'b00001, 1, 1, 0, 0);
        add(0, 5'b00010, 0, 5'b00010, 1, 1, 0, 0);
        add(0, 5'b00010, 0, 5'b00010, 3, 2, 1, 0);
        add(0, 5'b00010, 0, 5'b00010, 3, 2, 0, 0);
        add(0, 5'b00100, 0, 5'b00010, 3, 2, 0, 0);
        add(0, 5'b00100, 0, 5'b00100, 3, 2, 0, 0);
        add(0, 5'b00100, 0, 5'b00100, 7, 4, 1, 0);
        add(0, 5'b00100, 0, 5'b00100, 7, 4, 0, 0);
        // 7 -> 10
        add(0, 5'b01111, 0, 5'b00100, 7, 4, 0, 0);
        add(0, 5'b01111, 0, 5'b01111, 7, 4, 0, 0);
        add(0, 5'b01111, 0, 5'b01111, 10, 3, 1, 0);
        add(0, 5'b01111, 0, 5'b01111, 10, 3, 0, 0);
        // backward 10 -> 5: error, hold, clear
        add(0, 5'b00111, 0, 5'b01111, 10, 3, 0, 0);
        add(0, 5'b00111, 0, 5'b00111, 10, 3, 0, 0);
        add(0, 5'b00111, 0, 5'b00111, 5, 27, 1, 1);
        add(0, 5'b00111, 0, 5'b00111, 5, 27, 0, 1);
        add(0, 5'b00111, 1, 5'b00111, 5, 27, 0, 0);
        // backward 5 -> 0 with coincident clear: set wins
        add(0, 5'b00000, 0, 5'b00111, 5, 27, 0, 0);
        add(0, 5'b00000, 0, 5'b00000, 5, 27, 0, 0);
        add(0, 5'b00000, 1, 5'b00000, 0, 27, 1, 1);
        add(0, 5'b00000, 0, 5'b00000, 0, 27, 0, 1);
        // mid-operation reset, then resume
        add(1, 5'b00001, 0, 5'b00000, 0, 0, 0, 0);
        add(0, 5'b00001, 0, 5'b00000, 0, 0, 0, 0);
        add(0, 5'b00001, 0, 5'b00001, 0, 0, 0, 0);
        add(0, 5'b00001, 0, 5'b00001, 1, 1, 1, 0);
        foreach (vecs[i]) step_a(vecs[i], i);

        // three stages, two channels: settle ch0 at bin 2, then move only ch1
        repeat (2) step_b("b_reset", 1, 10'b00000_00011, '{10'd0, 10'd0, 10'd0, 2'b00, 2'b00});
        repeat (6) @(negedge rclk);
        rrst = 0;
        repeat (6) @(posedge rclk);
        settled = '{10'b00000_00011, 10'b00000_00010, 10'b00000_00010, 2'b00, 2'b00};
        step_b("b_settled", 0, 10'b00000_00011, settled);
        step_b("b_edge1", 0, 10'b00001_00011, settled);
        step_b("b_edge2", 0, 10'b00001_00011, settled);
        c1_seen = '{10'b00001_00011, 10'b00000_00010, 10'b00000_00010, 2'b00, 2'b00};
        step_b("b_edge3", 0, 10'b00001_00011, c1_seen);
        c1_adv = '{10'b00001_00011, 10'b00001_00010, 10'b00001_00010, 2'b10, 2'b00};
        step_b("b_edge4", 0, 10'b00001_00011, c1_adv);
        c1_done = '{10'b00001_00011, 10'b00001_00010, 10'b00001_00010, 2'b00, 2'b00};
        step_b("b_edge5", 0, 10'b00001_00011, c1_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
